// File: rtl/div_pkg.sv
// div_pkg: shared types, handshake levels and leading-zero helper for the iterative divider.
//   div_state_t : FSM states FREE, BYZERO, ON, FIX, END
//   DIV_START / DIV_STOP : start_i request levels
//   clz()       : leading-zero count over the low w bits, used only when DIV_EARLY_TERM_EN is defined
package div_pkg;

    typedef enum logic [2:0] {FREE, BYZERO, ON, FIX, END} div_state_t;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;
    localparam int   MAX_W     = 64;

    // Returns w when v is zero.
    function automatic int clz(input logic [MAX_W-1:0] v, input int w);
        int n;
        n = w;
        for (int i = 0; i < MAX_W; i++)
            if (i < w && v[i]) n = w - 1 - i;
        return n;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in, quo_in : partial remainder and dividend/quotient shift register
//   divisor        : divisor magnitude
//   rem_out, quo_out : state after shifting left one bit and trying the subtraction
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);
    logic [WIDTH:0] shifted, diff;

    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    // diff MSB is the borrow: set means the divisor did not fit.
    assign rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider retiring STEPS quotient bits per cycle.
//   clk, rst (async, active-low)
//   start_i (level request), annul_i (flush), signed_div_i, opdata1_i (dividend), opdata2_i (divisor)
//   busy_o, ready_o, div_zero_o, result_o = {remainder, quotient}
//   Optional build macro DIV_EARLY_TERM_EN skips the dividend's leading zeros.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic               div_zero_o,
    output logic [2*WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_STEP = CW'(STEPS);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - STEPS);

    div_state_t state, nxt;
    logic [CW-1:0] cnt, cnt0;
    logic [WIDTH-1:0] rem, quo, dvs, raw_a, a_mag, b_mag, a_pre;
    logic neg_q, neg_r, a_neg, b_neg, accept, a_zero;
    logic [WIDTH-1:0] rem_c [STEPS+1];
    logic [WIDTH-1:0] quo_c [STEPS+1];

    assign a_neg  = signed_div_i & opdata1_i[WIDTH-1];
    assign b_neg  = signed_div_i & opdata2_i[WIDTH-1];
    // Magnitude of MIN is MIN reinterpreted as unsigned, which is exactly right.
    assign a_mag  = a_neg ? -opdata1_i : opdata1_i;
    assign b_mag  = b_neg ? -opdata2_i : opdata2_i;
    assign accept = state == FREE && start_i == DIV_START && !annul_i;
    assign busy_o = state != FREE;

`ifdef DIV_EARLY_TERM_EN
    int lz_raw, lz;
    assign lz_raw = clz(MAX_W'(a_mag), WIDTH);
    // Whole STEPS groups only, so cnt still lands exactly on WIDTH.
    assign lz     = lz_raw - lz_raw % STEPS;
    assign cnt0   = CW'(lz);
    assign a_pre  = a_mag << lz;
    assign a_zero = a_mag == '0;
`else
    assign cnt0   = '0;
    assign a_pre  = a_mag;
    assign a_zero = 1'b0;
`endif

    assign rem_c[0] = rem;
    assign quo_c[0] = quo;
    for (genvar i = 0; i < STEPS; i++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_in  (rem_c[i]),
            .quo_in  (quo_c[i]),
            .divisor (dvs),
            .rem_out (rem_c[i+1]),
            .quo_out (quo_c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= FREE;
        else      state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            FREE:    nxt = !accept ? FREE : b_mag == '0 ? BYZERO : a_zero ? FIX : ON;
            ON:      nxt = annul_i ? FREE : cnt == CNT_LAST ? FIX : ON;
            FIX:     nxt = annul_i ? FREE : END;
            BYZERO:  nxt = cnt != '0 ? END : BYZERO;
            END:     nxt = start_i == DIV_STOP ? FREE : END;
            default: nxt = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            dvs        <= '0;
            raw_a      <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            ready_o    <= 1'b0;
            div_zero_o <= 1'b0;
            result_o   <= '0;
        end else begin
            case (state)
                FREE: if (accept) begin
                    rem   <= '0;
                    quo   <= a_pre;
                    dvs   <= b_mag;
                    raw_a <= opdata1_i;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    cnt   <= b_mag == '0 ? '0 : cnt0;
                end
                ON: begin
                    rem <= rem_c[STEPS];
                    quo <= quo_c[STEPS];
                    cnt <= cnt + CNT_STEP;
                end
                FIX: if (!annul_i) begin
                    result_o <= {neg_r ? -rem : rem, neg_q ? -quo : quo};
                    ready_o  <= 1'b1;
                end
                // Divide-by-zero spends one wait cycle so its latency stays at two.
                BYZERO: if (cnt == '0) begin
                    cnt <= 1;
                end else begin
                    result_o   <= {raw_a, {WIDTH{1'b1}}};
                    div_zero_o <= 1'b1;
                    ready_o    <= 1'b1;
                end
                END: if (start_i == DIV_STOP) begin
                    ready_o    <= 1'b0;
                    div_zero_o <= 1'b0;
                    result_o   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: self-checking bench for div_iter (STEPS=1 and STEPS=2 instances driven in parallel).
module tb_div_iter;
    logic        clk = 1'b0, rst = 1'b0;
    logic        start = 1'b0, annul = 1'b0, sgn = 1'b0;
    logic [31:0] op1 = '0, op2 = '0;
    logic        busy1, ready1, dz1, busy2, ready2, dz2;
    logic [63:0] res1, res2;
    int          compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32), .STEPS(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_div_i(sgn),
        .opdata1_i(op1), .opdata2_i(op2), .busy_o(busy1), .ready_o(ready1),
        .div_zero_o(dz1), .result_o(res1));

    div_iter #(.WIDTH(32), .STEPS(2)) dut2 (
        .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_div_i(sgn),
        .opdata1_i(op1), .opdata2_i(op2), .busy_o(busy2), .ready_o(ready2),
        .div_zero_o(dz2), .result_o(res2));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {div_zero, remainder, quotient} from plain integer arithmetic.
    function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {1'b0, r[31:0], q[31:0]};
        end
        ua = longint'(a);
        ub = longint'(b);
        uq = ua / ub;
        ur = ua % ub;
        return {1'b0, ur[31:0], uq[31:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s, input int st);
        logic [31:0] mag;
        int nb, lz;
        if (b == 0) return 2;
        mag = (s && a[31]) ? -a : a;
        nb = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) nb = i + 1;
        lz = 32 - nb;
        lz = lz - lz % st;
`ifdef DIV_EARLY_TERM_EN
        if (mag == 0) return 1;
        return (32 - lz) / st + 1;
`else
        return 32 / st + 1;
`endif
    endfunction

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
        logic [64:0] exp;
        logic [63:0] got1, got2;
        logic        gz1, gz2;
        int          l1, l2;
        exp = ref_div(a, b, s);
        l1 = 0;
        l2 = 0;
        got1 = '0;
        got2 = '0;
        gz1 = 1'b0;
        gz2 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        sgn = s;
        op1 = a;
        op2 = b;
        @(posedge clk);
        #1;
        op1 = $urandom;
        op2 = $urandom;
        sgn = 1'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (l1 == 0 && ready1) begin l1 = k; got1 = res1; gz1 = dz1; end
            if (l2 == 0 && ready2) begin l2 = k; got2 = res2; gz2 = dz2; end
            if (l1 != 0 && l2 != 0) break;
        end
        check({tag, " lat1"}, 64'(l1), 64'(ref_lat(a, b, s, 1)));
        check({tag, " lat2"}, 64'(l2), 64'(ref_lat(a, b, s, 2)));
        check({tag, " res1"}, got1, exp[63:0]);
        check({tag, " res2"}, got2, exp[63:0]);
        check({tag, " dz1"}, 64'(gz1), 64'(exp[64]));
        check({tag, " dz2"}, 64'(gz2), 64'(exp[64]));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " drop"}, {res1[61:0], ready1, dz1}, 64'd0);
        check({tag, " drop2"}, {res2[60:0], ready2, dz2, busy1}, 64'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;
        logic        rs;
        #12;
        check("reset1", {res1[60:0], busy1, ready1, dz1}, 64'd0);
        check("reset2", {res2[60:0], busy2, ready2, dz2}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run(32'd100, 32'd7, 1'b0, "u100_7");
        run(-32'sd7, 32'd2, 1'b1, "s-7_2");
        run(32'd7, -32'sd2, 1'b1, "s7_-2");
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "smin_-1");
        run(32'hFFFF_FFFF, 32'd1, 1'b0, "umax_1");
        run(32'd5, 32'd0, 1'b0, "u5_0");
        run(32'd3, 32'd1, 1'b0, "u3_1");
        run(32'd0, 32'd5, 1'b1, "s0_5");

        // Flush on ON cycle 10: back to FREE and no result ever appears.
        @(negedge clk);
        start = 1'b1;
        sgn = 1'b0;
        op1 = 32'd123456;
        op2 = 32'd7;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("annul busy", {62'd0, busy1, busy2}, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready1 || ready2) seen++;
        end
        check("annul ready", 64'(seen), 64'd0);
        run(32'd9, 32'd3, 1'b0, "u9_3");

        // Asynchronous reset in the middle of ON.
        @(negedge clk);
        start = 1'b1;
        op1 = 32'd1000;
        op2 = 32'd3;
        repeat (6) @(posedge clk);
        #2;
        check("pre-rst busy", 64'(busy1), 64'd1);
        rst = 1'b0;
        #1;
        check("rst async1", {res1[60:0], busy1, ready1, dz1}, 64'd0);
        check("rst async2", {res2[60:0], busy2, ready2, dz2}, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int n = 0; n < 16; n++) begin
            ra = $urandom;
            rb = (n % 4 == 0) ? 32'($urandom_range(0, 3)) : (n % 4 == 1) ? $urandom : 32'($urandom_range(1, 65535));
            rs = 1'($urandom);
            if (n % 5 == 2) ra = 32'($urandom_range(0, 300));
            run(ra, rb, rs, $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
